// File: rtl/uart_rx_fifo_if.sv
// Bus-side signal bundle of the UART receiver: serial input, pop strobe,
// FIFO head word, occupancy and error pulses.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  logic                          rx_in;
  logic                          data_rd;
  logic [31:0]                   data;
  logic [$clog2(FIFO_DEPTH):0]   level;
  logic                          frame_err;
  logic                          overrun_err;

  // master: SoC side (drives the line and the pop strobe)
  modport master (
    output rx_in, data_rd,
    input  data, level, frame_err, overrun_err
  );

  // slave: the receiver itself
  modport slave (
    input  rx_in, data_rd,
    output data, level, frame_err, overrun_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a circular receive FIFO; an empty FIFO reads as
// all-ones so the legacy data-ready test !(&data) keeps working.
module uart_rx_fifo #(
  parameter int SYSTEM_CLK = 100_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input logic           clk,
  input logic           resetn,
  uart_rx_fifo_if.slave bus
);
  localparam int DIV   = SYSTEM_CLK / BAUDRATE;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);
  localparam logic [LVL_W-1:0] FULL_CNT = LVL_W'(FIFO_DEPTH);

  // ---------------- synchroniser and edge detect ----------------
  logic [1:0] sync_reg;
  logic       rxs_prev_reg;
  logic       rxs;

  assign rxs = sync_reg[1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_reg     <= 2'b11;
      rxs_prev_reg <= 1'b1;
    end else begin
      sync_reg     <= {sync_reg[0], bus.rx_in};
      rxs_prev_reg <= rxs;
    end
  end

  // ---------------- receive FSM ----------------
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             frame_err_reg;
  logic             push_fire;

  // A good stop bit hands the assembled byte straight to the FIFO on this edge.
  assign push_fire = (state_reg == S_STOP) && (cnt_reg == BIT_END) && rxs;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (rxs_prev_reg && !rxs) begin
            state_reg <= S_START;
            cnt_reg   <= '0;
          end
        end
        S_START: begin
          if (cnt_reg == HALF_END) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            state_reg   <= rxs ? S_IDLE : S_DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_reg == BIT_END) begin
            cnt_reg     <= '0;
            shift_reg   <= {rxs, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= S_STOP;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_reg == BIT_END) begin
            cnt_reg <= '0;
            if (rxs) begin
              state_reg <= S_IDLE;
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= S_WAIT_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          // a held-low line must return high before a new start is armed
          if (rxs) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // ---------------- receive FIFO ----------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_reg;
  logic [PTR_W-1:0] rptr_reg;
  logic [LVL_W-1:0] count_reg;
  logic             overrun_reg;
  logic             fifo_empty;
  logic             fifo_full;
  logic             do_pop;
  logic             do_push;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_CNT);
  assign do_pop     = bus.data_rd && !fifo_empty;
  // a simultaneous pop frees the slot, so a full FIFO can still accept
  assign do_push    = push_fire && (!fifo_full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_reg] <= shift_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_reg    <= '0;
      rptr_reg    <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= push_fire && fifo_full && !do_pop;
      if (do_push) begin
        wptr_reg <= wptr_reg + 1'b1;
      end
      if (do_pop) begin
        rptr_reg <= rptr_reg + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (do_pop && !do_push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  assign bus.data        = fifo_empty ? 32'hFFFF_FFFF : {24'h0, mem[rptr_reg]};
  assign bus.level       = count_reg;
  assign bus.frame_err   = frame_err_reg;
  assign bus.overrun_err = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised scoreboard bench for uart_rx_fifo: a queue-based FIFO model
// predicts popped words; a negedge monitor checks every pop and counts pulses.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int SYS   = 100_000_000;
  localparam int BAUD  = 1_000_000;
  localparam int DEPTH = 16;
  localparam int DIV   = SYS / BAUD;
  localparam int HALF  = DIV / 2;
  // Edge index (counted from the first edge that sees the start bit) at which
  // the stop bit is sampled: 2 edges through synchroniser/edge detect, half a
  // bit to the start check, then 8 data bits and the stop bit at DIV each.
  localparam int STOP_EDGE = 2 + HALF + 9 * DIV;
  localparam int RESET_AT  = 450;

  logic clk = 1'b0;
  logic resetn;

  uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(
    .SYSTEM_CLK(SYS),
    .BAUDRATE  (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fe_seen = 0;
  int ov_seen = 0;
  int exp_fe = 0;
  int exp_ov = 0;
  logic [7:0]  model_q[$];
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every pop is compared against the queued expectation
  always @(negedge clk) begin
    if (resetn === 1'b1 && bus.data_rd === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_data: got 0x%08h with no expectation queued", bus.data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("pop_data", bus.data, e);
        $display("pop  data=0x%08h expected=0x%08h", bus.data, e);
      end
    end
    if (bus.frame_err === 1'b1) fe_seen++;
    if (bus.overrun_err === 1'b1) ov_seen++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic model_push(input logic [7:0] b);
    if (model_q.size() == DEPTH) exp_ov++;
    else model_q.push_back(b);
  endtask

  task automatic queue_pop_expect();
    if (model_q.size() == 0) exp_q.push_back(32'hFFFF_FFFF);
    else exp_q.push_back({24'h0, model_q.pop_front()});
  endtask

  task automatic pop();
    bus.data_rd = 1'b1;
    queue_pop_expect();
    step();
    bus.data_rd = 1'b0;
  endtask

  task automatic check_level(input string name);
    chk(name, 32'(bus.level), 32'(model_q.size()));
  endtask

  task automatic check_errs(input string name);
    chk({name, "_frame_err"}, 32'(fe_seen), 32'(exp_fe));
    chk({name, "_overrun"}, 32'(ov_seen), 32'(exp_ov));
  endtask

  task automatic check_reset_values(input string name);
    chk({name, "_data"}, bus.data, 32'hFFFF_FFFF);
    chk({name, "_level"}, 32'(bus.level), 32'd0);
    chk({name, "_frame_err"}, 32'(bus.frame_err), 32'd0);
    chk({name, "_overrun"}, 32'(bus.overrun_err), 32'd0);
  endtask

  task automatic do_reset();
    resetn      = 1'b0;
    bus.rx_in   = 1'b1;
    bus.data_rd = 1'b0;
    idle(4);
    resetn = 1'b1;
    model_q.delete();
    step();
  endtask

  // mode 0: plain frame, 1: check push latency, 2: pop in the stop-sample
  // cycle, 3: reset pulse in the middle of the data bits (frame abandoned)
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int mode);
    logic [9:0] frame;
    int base;
    frame = {stop_bit, b, 1'b0};
    base  = model_q.size();
    $display("send byte=0x%02h stop=%0d mode=%0d", b, stop_bit, mode);
    for (int c = 0; c < 10 * DIV; c++) begin
      bus.rx_in = frame[c / DIV];
      step();
      if (mode == 1 && c == STOP_EDGE - 1) chk("latency_before", 32'(bus.level), 32'(base));
      if (mode == 1 && c == STOP_EDGE)     chk("latency_after", 32'(bus.level), 32'(base + 1));
      if (mode == 2 && c == STOP_EDGE - 1) begin
        bus.data_rd = 1'b1;
        queue_pop_expect();
      end
      if (mode == 2 && c == STOP_EDGE) begin
        bus.data_rd = 1'b0;
        chk("full_pushpop_level", 32'(bus.level), 32'(DEPTH));
      end
      if (mode == 3 && c == RESET_AT) begin
        resetn    = 1'b0;
        bus.rx_in = 1'b1;
        step();
        resetn = 1'b1;
        model_q.delete();
        check_reset_values("mid_frame_reset");
        return;
      end
    end
    if (stop_bit) model_push(b);
    else exp_fe++;
  endtask

  logic [7:0] rb;
  int n;

  initial begin
    bus.rx_in   = 1'b1;
    bus.data_rd = 1'b0;
    resetn      = 1'b0;
    do_reset();
    check_reset_values("reset");

    // single frame with exact push latency
    send_frame(8'h55, 1'b1, 1);
    idle(3);
    chk("head_55", bus.data, 32'h0000_0055);
    check_errs("after_55");

    // empty pop is harmless, then a byte is popped back out
    do_reset();
    pop();
    check_level("empty_pop_level");
    chk("empty_pop_data", bus.data, 32'hFFFF_FFFF);
    send_frame(8'hA3, 1'b1, 0);
    idle(3);
    pop();
    chk("after_pop_data", bus.data, 32'hFFFF_FFFF);
    check_level("after_pop_level");

    // overflow by one byte
    for (int i = 0; i <= DEPTH; i++) begin
      send_frame(8'(i), 1'b1, 0);
      idle(3);
    end
    check_level("full_level");
    check_errs("overflow");
    repeat (DEPTH) pop();
    check_level("drained_level");

    // pointer wrap-around
    for (int i = 0; i < 4; i++) begin
      send_frame(8'($urandom), 1'b1, 0);
      idle(2);
    end
    check_level("wrap_level");
    repeat (4) pop();

    // full FIFO: a byte lands in the same cycle as a pop
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'($urandom), 1'b1, 0);
      idle(2);
    end
    send_frame(8'($urandom), 1'b1, 2);
    idle(3);
    check_errs("full_pushpop");
    check_level("full_pushpop_model");
    repeat (DEPTH) pop();
    check_level("drain2_level");

    // bad stop bit followed by a long break
    send_frame(8'h7E, 1'b0, 0);
    idle(50 * DIV);
    bus.rx_in = 1'b1;
    idle(50);
    check_errs("break");
    check_level("break_level");
    send_frame(8'h31, 1'b1, 0);
    idle(3);
    pop();

    // short glitch on an idle line
    bus.rx_in = 1'b0;
    idle(30);
    bus.rx_in = 1'b1;
    idle(300);
    check_level("glitch_level");
    check_errs("glitch");

    // reset in the middle of a frame throws away FIFO contents and the frame
    send_frame(8'h12, 1'b1, 0);
    idle(2);
    send_frame(8'h34, 1'b1, 0);
    idle(2);
    send_frame(8'h5A, 1'b1, 3);
    idle(50);
    check_level("post_reset_level");
    send_frame(8'hC4, 1'b1, 0);
    idle(3);
    pop();

    // randomised traffic
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      send_frame(rb, 1'b1, 0);
      idle($urandom_range(1, 40));
      n = $urandom_range(0, 2);
      repeat (n) pop();
      check_level("random_level");
    end
    while (model_q.size() != 0) pop();
    check_level("final_level");
    check_errs("final");
    idle(2);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
